// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the dual-read-port register file and its users.
//   - Register index map of the low (exported) registers.
//   - Default reset values of the UART configuration and clock-divider
//     registers.
// -----------------------------------------------------------------------------
package reg_file_pkg;

  // Register index map of the exported configuration block
  localparam int REG_ALU_A     = 0;
  localparam int REG_ALU_B     = 1;
  localparam int REG_UART_CFG  = 2;
  localparam int REG_DIV_RATIO = 3;

  // UART config: prescale 32, parity enabled
  localparam logic [7:0] DEF_RST_VAL2 = 8'b1000_0001;
  // Clock divide ratio
  localparam logic [7:0] DEF_RST_VAL3 = 8'h20;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// -----------------------------------------------------------------------------
// reg_file_rd_port
// One registered read port of reg_file_dp: read mux over the flattened
// register array, write-first bypass, range check and valid/err pulses.
//
// Ports:
//   CLK, RST       clock, asynchronous active-low reset
//   rd_en, rd_addr read strobe and address
//   wr_en, wr_addr write strobe and address seen this cycle (for bypass)
//   wr_merged      post-mask value the current write will store
//   regs_flat      all DEPTH registers concatenated, reg0 in LSBs
//   rd_data        registered read data (holds when rd_en = 0)
//   rd_valid       1-cycle pulse, rd_data valid
//   rd_err         1-cycle pulse, rd_addr was >= DEPTH
// -----------------------------------------------------------------------------
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   rd_en,
  input  logic [ADDR-1:0]        rd_addr,
  input  logic                   wr_en,
  input  logic [ADDR-1:0]        wr_addr,
  input  logic [WIDTH-1:0]       wr_merged,
  input  logic [DEPTH*WIDTH-1:0] regs_flat,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   rd_err
);

  logic             in_range;
  logic             bypass;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] rd_next;

  assign in_range = int'(rd_addr) < DEPTH;
  // A same-cycle write to the same address wins over the stored value
  assign bypass   = wr_en && (wr_addr == rd_addr);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR'(i)) sel_data = regs_flat[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rd_next = '0;
    if (in_range) rd_next = bypass ? wr_merged : sel_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !in_range;
      if (rd_en) rd_data <= rd_next;
    end
  end

endmodule : reg_file_rd_port

// File: rtl/reg_file_dp.sv
// -----------------------------------------------------------------------------
// reg_file_dp
// Register file with one masked write port and two independent registered
// read ports (A: system controller, B: ALU operand fetch). The low NUM_EXP
// registers are exported continuously as the UART / clock-divider config bus.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   WrEn, WrAddr, WrData     write strobe, address, data
//   WrMask                   per-bit write enable (1 = bit updated)
//   WrErr                    1-cycle pulse, write address >= DEPTH
//   RdEnA/B, RdAddrA/B       read strobes and addresses
//   RdDataA/B                registered read data, 1-cycle latency
//   RdValidA/B, RdErrA/B     1-cycle valid / out-of-range pulses
//   EXP_REGS                 registers 0..NUM_EXP-1, reg0 in LSBs
// -----------------------------------------------------------------------------
module reg_file_dp
  import reg_file_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 16,
  parameter int               ADDR     = 4,
  parameter int               NUM_EXP  = 4,
  parameter logic [WIDTH-1:0] RST_VAL2 = WIDTH'(DEF_RST_VAL2),
  parameter logic [WIDTH-1:0] RST_VAL3 = WIDTH'(DEF_RST_VAL3)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic [ADDR-1:0]          WrAddr,
  input  logic [WIDTH-1:0]         WrData,
  input  logic [WIDTH-1:0]         WrMask,
  input  logic                     RdEnA,
  input  logic [ADDR-1:0]          RdAddrA,
  output logic [WIDTH-1:0]         RdDataA,
  output logic                     RdValidA,
  output logic                     RdErrA,
  input  logic                     RdEnB,
  input  logic [ADDR-1:0]          RdAddrB,
  output logic [WIDTH-1:0]         RdDataB,
  output logic                     RdValidB,
  output logic                     RdErrB,
  output logic                     WrErr,
  output logic [NUM_EXP*WIDTH-1:0] EXP_REGS
);

  logic [WIDTH-1:0]       regs [DEPTH];
  logic [DEPTH*WIDTH-1:0] regs_flat;
  logic                   wr_in_range;
  logic [WIDTH-1:0]       wr_cur;
  logic [WIDTH-1:0]       wr_merged;

  assign wr_in_range = int'(WrAddr) < DEPTH;

  always_comb begin
    wr_cur = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (WrAddr == ADDR'(i)) wr_cur = regs[i];
    end
  end

  assign wr_merged = (wr_cur & ~WrMask) | (WrData & WrMask);

  // NOTE: the array is built from flops and is reset explicitly, because the
  // config registers must come up with defined values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == REG_UART_CFG)       regs[i] <= RST_VAL2;
        else if (i == REG_DIV_RATIO) regs[i] <= RST_VAL3;
        else                         regs[i] <= '0;
      end
      WrErr <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WrEn && WrAddr == ADDR'(i)) regs[i] <= wr_merged;
      end
      WrErr <= WrEn && !wr_in_range;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
  end

  for (genvar g = 0; g < NUM_EXP; g++) begin : g_exp
    assign EXP_REGS[g*WIDTH +: WIDTH] = regs[g];
  end

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_rd_a (
    .CLK       (CLK),
    .RST       (RST),
    .rd_en     (RdEnA),
    .rd_addr   (RdAddrA),
    .wr_en     (WrEn),
    .wr_addr   (WrAddr),
    .wr_merged (wr_merged),
    .regs_flat (regs_flat),
    .rd_data   (RdDataA),
    .rd_valid  (RdValidA),
    .rd_err    (RdErrA)
  );

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_rd_b (
    .CLK       (CLK),
    .RST       (RST),
    .rd_en     (RdEnB),
    .rd_addr   (RdAddrB),
    .wr_en     (WrEn),
    .wr_addr   (WrAddr),
    .wr_merged (wr_merged),
    .regs_flat (regs_flat),
    .rd_data   (RdDataB),
    .rd_valid  (RdValidB),
    .rd_err    (RdErrB)
  );

endmodule : reg_file_dp
